// File: rtl/window_median.sv
// 3x3 window median stage.
// Takes one pre-sorted column per valid cycle (largest, middle, smallest) and
// keeps the last three columns of the current line. The median of the 3x3
// window is the median of three partial results:
//   max of the smallest values, median of the middle values, min of the largest.
// The result goes through two register stages, so a column sampled at edge k
// that completes a window produces its median after edge k+2.
module window_median #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             line_start,
  input  logic [WIDTH-1:0] L_in,
  input  logic [WIDTH-1:0] M_in,
  input  logic [WIDTH-1:0] S_in,
  output logic [WIDTH-1:0] med_out,
  output logic             out_valid
);

  // Unsigned three-input minimum.
  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] t;
    if (a < b) begin
      t = a;
    end else begin
      t = b;
    end
    if (c < t) begin
      t = c;
    end else begin
      t = t;
    end
    return t;
  endfunction

  // Unsigned three-input maximum.
  function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] t;
    if (a > b) begin
      t = a;
    end else begin
      t = b;
    end
    if (c > t) begin
      t = c;
    end else begin
      t = t;
    end
    return t;
  endfunction

  // Unsigned three-input median: max(min(a,b), min(max(a,b), c)).
  // Ties always select one of the equal values, so the result is exact.
  function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] lo_ab;
    logic [WIDTH-1:0] hi_ab;
    logic [WIDTH-1:0] t;
    if (a < b) begin
      lo_ab = a;
      hi_ab = b;
    end else begin
      lo_ab = b;
      hi_ab = a;
    end
    if (c < hi_ab) begin
      t = c;
    end else begin
      t = hi_ab;
    end
    if (t > lo_ab) begin
      return t;
    end else begin
      return lo_ab;
    end
  endfunction

  // Column history: index 0 is the newest column, index 2 the oldest.
  logic [WIDTH-1:0] l_q [3];
  logic [WIDTH-1:0] l_d [3];
  logic [WIDTH-1:0] m_q [3];
  logic [WIDTH-1:0] m_d [3];
  logic [WIDTH-1:0] s_q [3];
  logic [WIDTH-1:0] s_d [3];
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             hist_valid_q;
  logic             hist_valid_d;

  // Stage 1 partial results.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] md_q;
  logic [WIDTH-1:0] md_d;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] lo_d;
  logic             s1_valid_q;
  logic             s1_valid_d;

  // Stage 2 output.
  logic [WIDTH-1:0] med_q;
  logic [WIDTH-1:0] med_d;
  logic             out_valid_q;
  logic             out_valid_d;

  // Next-state logic: history shift with fill count, then the two compute stages.
  always_comb begin
    l_d          = l_q;
    m_d          = m_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    hist_valid_d = 1'b0;
    if (in_valid) begin
      l_d[2] = l_q[1];
      l_d[1] = l_q[0];
      l_d[0] = L_in;
      m_d[2] = m_q[1];
      m_d[1] = m_q[0];
      m_d[0] = M_in;
      s_d[2] = s_q[1];
      s_d[1] = s_q[0];
      s_d[0] = S_in;
      // A line start restarts the fill; older columns stay in the regs but
      // cannot reach a valid window until two more columns arrive.
      if (line_start) begin
        cnt_d = 2'd1;
      end else if (cnt_q == 2'd3) begin
        cnt_d = 2'd3;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
      hist_valid_d = (cnt_d == 2'd3);
    end else begin
      cnt_d        = cnt_q;
      hist_valid_d = 1'b0;
    end

    hi_d       = min3(l_q[0], l_q[1], l_q[2]);
    md_d       = med3(m_q[0], m_q[1], m_q[2]);
    lo_d       = max3(s_q[0], s_q[1], s_q[2]);
    s1_valid_d = hist_valid_q;

    // The output register only loads on a valid window so it holds otherwise.
    if (s1_valid_q) begin
      med_d = med3(lo_q, md_q, hi_q);
    end else begin
      med_d = med_q;
    end
    out_valid_d = s1_valid_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        l_q[i] <= '0;
        m_q[i] <= '0;
        s_q[i] <= '0;
      end
      cnt_q        <= 2'd0;
      hist_valid_q <= 1'b0;
      hi_q         <= '0;
      md_q         <= '0;
      lo_q         <= '0;
      s1_valid_q   <= 1'b0;
      med_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      l_q          <= l_d;
      m_q          <= m_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      hist_valid_q <= hist_valid_d;
      hi_q         <= hi_d;
      md_q         <= md_d;
      lo_q         <= lo_d;
      s1_valid_q   <= s1_valid_d;
      med_q        <= med_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign med_out   = med_q;
  assign out_valid = out_valid_q;

endmodule
